// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the main-memory arbiter.
//               arb_state_t names the sequencing phases, grant_t names the
//               winning requester, and the latency bounds give the legal
//               range of the MEM_LATENCY parameter (the counter is 4 bits).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam int unsigned c_MEM_LATENCY_MIN = 1;
    localparam int unsigned c_MEM_LATENCY_MAX = 15;
    localparam int unsigned c_CNT_WIDTH       = 4;

endpackage
`default_nettype wire

// File: rtl/main_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_arbiter_if
// Description : Bundle of the instruction-side, data-side and main-memory
//               signals around the arbiter.
//               slave  : the arbiter's view (takes requests, drives memory)
//               master : the environment's view (requesters plus memory)
//               Ports  : i_req/i_addr/i_ack/i_rdata      instruction side
//                        d_req/d_we/d_addr/d_wdata/
//                        d_ack/d_rdata                   data side
//                        mem_re/mem_we/mem_addr/mem_wd/
//                        mem_rd                          memory port
//                        busy                            arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface main_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [DATA_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    logic                  busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_re, mem_we, mem_addr, mem_wd, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_re, mem_we, mem_addr, mem_wd, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin grant logic. A lone request wins; on a
//               conflict the side not granted last wins. The last-grant
//               register only moves when the caller strobes i_take.
//               Ports  : clk, reset (sync, active-low)
//                        i_req_inst, i_req_data  requests
//                        i_take                  grant consumed this cycle
//                        o_grant                 combinational winner
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req_inst,
    input  logic   i_req_data,
    input  logic   i_take,
    output grant_t o_grant
);

    grant_t r_last_grant;
    grant_t w_grant;

    always_comb begin
        w_grant = GRANT_I;
        if (i_req_inst && i_req_data) begin
            w_grant = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (i_req_data) begin
            w_grant = GRANT_D;
        end
    end

    // Resetting to GRANT_I makes the data side win the first conflict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= GRANT_I;
        end else if (i_take) begin
            r_last_grant <= w_grant;
        end
    end

    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_arbiter
// Description : Serialises instruction-fetch reads and data-side reads/writes
//               onto the single-ported main memory. Each access occupies the
//               memory for MEM_LATENCY cycles (legal 1..15) and completes
//               with a one-cycle ack carrying the read word (0 for writes).
//               Ports  : clk                      clock
//                        reset                    sync, active-low
//                        bus (slave modport)      requesters + memory port
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    main_mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_ACCESS = 2'(ACCESS);
    localparam logic [1:0] S_RESP   = 2'(RESP);

    localparam logic [c_CNT_WIDTH-1:0] c_CNT_LOAD  = c_CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0]  c_WORD_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    logic [1:0]             r_state;
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_addr;
    logic                   r_we;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;
    grant_t                 r_grant;

    grant_t                 w_grant;
    logic                   w_take;
    logic                   w_access;
    logic                   w_resp;
    logic                   w_last;

    assign w_take   = (r_state == S_IDLE) && (bus.i_req || bus.d_req);
    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);
    assign w_last   = (r_cnt == '0);

    rr_arbiter2 u_rr_arbiter2 (
        .clk        (clk),
        .reset      (reset),
        .i_req_inst (bus.i_req),
        .i_req_data (bus.d_req),
        .i_take     (w_take),
        .o_grant    (w_grant)
    );

    // Request fields are latched only at the grant; anything the requesters
    // change afterwards is ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_grant <= GRANT_I;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= c_CNT_LOAD;
                        r_grant <= w_grant;
                        if (w_grant == GRANT_D) begin
                            r_addr  <= bus.d_addr;
                            r_we    <= bus.d_we;
                            r_wdata <= bus.d_wdata;
                        end else begin
                            r_addr  <= bus.i_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_last) begin
                        r_state <= S_RESP;
                        r_rdata <= r_we ? '0 : bus.mem_rd;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The write strobe fires only on the final ACCESS cycle, so a reset that
    // lands earlier in the access leaves memory untouched.
    assign bus.mem_re   = w_access && !r_we;
    assign bus.mem_we   = w_access && r_we && w_last;
    assign bus.mem_addr = w_access ? (r_addr & c_WORD_MASK) : '0;
    assign bus.mem_wd   = (w_access && r_we) ? r_wdata : '0;

    assign bus.i_ack    = w_resp && (r_grant == GRANT_I);
    assign bus.d_ack    = w_resp && (r_grant == GRANT_D);
    assign bus.i_rdata  = bus.i_ack ? r_rdata : '0;
    assign bus.d_rdata  = bus.d_ack ? r_rdata : '0;

    assign bus.busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_main_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_mem_arbiter
// Description : Self-checking bench for main_mem_arbiter. Two instances are
//               built: MEM_LATENCY=4 (main) and MEM_LATENCY=1 (short path).
//               A word-addressed memory model sits behind both memory ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    main_mem_arbiter_if #(.DATA_WIDTH(DW)) bus4 ();
    main_mem_arbiter_if #(.DATA_WIDTH(DW)) bus1 ();

    main_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(4)) u_dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus4)
    );

    main_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    // Environment memory (what the DUT sees) and reference memory (what the
    // specification says memory should hold).
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        poke_en;
    logic [11:0] poke_idx;
    logic [31:0] poke_data;

    assign bus4.mem_rd = mem[bus4.mem_addr[13:2]];
    assign bus1.mem_rd = mem[bus1.mem_addr[13:2]];

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_idx] <= poke_data;
        end else begin
            if (bus4.mem_we) mem[bus4.mem_addr[13:2]] <= bus4.mem_wd;
            if (bus1.mem_we) mem[bus1.mem_addr[13:2]] <= bus1.mem_wd;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic idle_inputs();
        bus4.i_req = 0; bus4.i_addr = 0; bus4.d_req = 0; bus4.d_we = 0;
        bus4.d_addr = 0; bus4.d_wdata = 0;
        bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0;
    endtask

    task automatic poke(input logic [11:0] idx, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic chk_idle4(input string tag);
        check({tag, "_ctl"}, {bus4.mem_re, bus4.mem_we, bus4.i_ack, bus4.d_ack, bus4.busy}, 0);
        check({tag, "_maddr"}, bus4.mem_addr, 0);
        check({tag, "_mwd"}, bus4.mem_wd, 0);
        check({tag, "_rdata"}, {bus4.i_rdata, bus4.d_rdata}, 0);
    endtask

    // One isolated transaction on the MEM_LATENCY=4 instance.
    task automatic tx4(input vec_t v, input string tag);
        int n, re_cnt, we_cnt;
        bit got;
        logic [31:0] rd;
        logic other;
        @(negedge clk);
        if (v.is_d) begin
            bus4.d_req = 1; bus4.d_we = v.we; bus4.d_addr = v.addr; bus4.d_wdata = v.wdata;
        end else begin
            bus4.i_req = 1; bus4.i_addr = v.addr;
        end
        n = 0; re_cnt = 0; we_cnt = 0; got = 0; rd = 0; other = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus4.mem_re) re_cnt++;
            if (bus4.mem_we) begin
                we_cnt++;
                check({tag, "_mwd"}, bus4.mem_wd, v.wdata);
            end
            if (bus4.mem_re || bus4.mem_we)
                check({tag, "_maddr"}, bus4.mem_addr, v.addr & 32'hFFFF_FFFC);
            if (v.is_d ? bus4.d_ack : bus4.i_ack) begin
                got   = 1;
                rd    = v.is_d ? bus4.d_rdata : bus4.i_rdata;
                other = v.is_d ? bus4.i_ack : bus4.d_ack;
            end
        end
        bus4.i_req = 0; bus4.d_req = 0;
        check({tag, "_latency"}, n, 5);
        check({tag, "_rdata"}, rd, v.exp_rdata);
        check({tag, "_other_ack"}, other, 0);
        check({tag, "_re_cycles"}, re_cnt, v.we ? 0 : 4);
        check({tag, "_we_pulses"}, we_cnt, v.we ? 1 : 0);
        if (v.is_d && v.we) ref_mem[v.addr[13:2]] = v.wdata;
    endtask

    // Both sides request in the same cycle and hold until acked.
    task automatic conflict(input int exp_ti, input int exp_td, input string tag);
        int n, ti, td;
        @(negedge clk);
        bus4.i_req = 1; bus4.i_addr = 32'h0000_1006;
        bus4.d_req = 1; bus4.d_we = 0; bus4.d_addr = 32'h0000_1008;
        n = 0; ti = 0; td = 0;
        while ((ti == 0 || td == 0) && n < 60) begin
            @(negedge clk);
            n++;
            if (bus4.i_ack) begin
                ti = n;
                check({tag, "_i_rdata"}, bus4.i_rdata, ref_mem[12'h401]);
                bus4.i_req = 0;
            end
            if (bus4.d_ack) begin
                td = n;
                check({tag, "_d_rdata"}, bus4.d_rdata, ref_mem[12'h402]);
                bus4.d_req = 0;
            end
        end
        bus4.i_req = 0; bus4.d_req = 0;
        check({tag, "_i_ack_cycle"}, ti, exp_ti);
        check({tag, "_d_ack_cycle"}, td, exp_td);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{is_d: 0, we: 0, addr: 32'h0000_1006, wdata: 0,            exp_rdata: 32'hDEAD_BEEF};
        vecs[1] = '{is_d: 1, we: 1, addr: 32'h0000_2000, wdata: 32'h1234_5678, exp_rdata: 0};
        vecs[2] = '{is_d: 1, we: 0, addr: 32'h0000_2000, wdata: 0,            exp_rdata: 32'h1234_5678};
        vecs[3] = '{is_d: 1, we: 1, addr: 32'h0000_3ABC, wdata: 32'hCAFE_F00D, exp_rdata: 0};
        vecs[4] = '{is_d: 0, we: 0, addr: 32'h0000_3ABF, wdata: 0,            exp_rdata: 32'hCAFE_F00D};
        vecs[5] = '{is_d: 1, we: 0, addr: 32'h0000_1005, wdata: 0,            exp_rdata: 32'hDEAD_BEEF};

        poke_en = 0; poke_idx = 0; poke_data = 0;
        rst_n = 0;
        idle_inputs();
        for (int k = 0; k < 128; k++) poke(12'(k), $urandom);
        poke(12'h401, 32'hDEAD_BEEF);
        poke(12'h402, 32'h600D_F00D);
        poke(12'h800, 32'h0000_0000);
        poke(12'hEAF, 32'h0000_0000);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Reset state
        chk_idle4("reset");
        check("reset_dut1_busy", {bus1.busy, bus1.i_ack, bus1.mem_re}, 0);

        // First conflict after reset: D wins, I follows one slot later.
        conflict(11, 5, "conflict1");

        // Table-driven isolated transactions.
        for (int k = 0; k < 6; k++) tx4(vecs[k], $sformatf("vec%0d", k));

        // Last grant was D, so the next conflict goes to I first.
        conflict(5, 11, "conflict2");

        // D arrives mid-access of an I read; its fields change before IDLE.
        begin : d_during_i
            int n, ti, td;
            @(negedge clk);
            bus4.i_req = 1; bus4.i_addr = 32'h0000_1008;
            n = 0; ti = 0; td = 0;
            while ((ti == 0 || td == 0) && n < 60) begin
                @(negedge clk);
                n++;
                if (n == 2) begin
                    bus4.i_addr = 32'h0000_1004;
                    bus4.d_req = 1; bus4.d_we = 1;
                    bus4.d_addr = 32'h0000_0100; bus4.d_wdata = 32'h1111_1111;
                end
                if (bus4.i_ack) begin
                    ti = n;
                    check("late_d_i_rdata", bus4.i_rdata, 32'h600D_F00D);
                    bus4.i_req = 0;
                    bus4.d_addr = 32'h0000_0104; bus4.d_wdata = 32'h2222_2222;
                end
                if (bus4.d_ack) begin
                    td = n;
                    bus4.d_req = 0;
                end
            end
            bus4.i_req = 0; bus4.d_req = 0;
            check("late_d_i_ack_cycle", ti, 5);
            check("late_d_d_ack_cycle", td, 11);
            @(negedge clk);
            check("late_d_new_word", mem[12'h041], 32'h2222_2222);
            check("late_d_old_word", mem[12'h040], ref_mem[12'h040]);
            ref_mem[12'h041] = 32'h2222_2222;
        end

        // MEM_LATENCY=1: back-to-back reads, acks three cycles apart.
        begin : lat1
            int n, k, t0, t1;
            bit just_acked;
            logic [31:0] addrs [2];
            addrs[0] = 32'h0000_0010;
            addrs[1] = 32'h0000_0027;
            @(negedge clk);
            bus1.i_req = 1; bus1.i_addr = addrs[0];
            n = 0; k = 0; t0 = 0; t1 = 0; just_acked = 0;
            while (k < 2 && n < 30) begin
                @(negedge clk);
                n++;
                if (bus1.i_ack) begin
                    check($sformatf("lat1_rdata%0d", k), bus1.i_rdata, ref_mem[addrs[k][13:2]]);
                    if (k == 0) t0 = n; else t1 = n;
                    k++;
                    bus1.i_req = 0;
                    just_acked = 1;
                end else if (just_acked && k == 1) begin
                    bus1.i_req = 1; bus1.i_addr = addrs[1];
                    just_acked = 0;
                end
            end
            bus1.i_req = 0;
            check("lat1_first_ack", t0, 2);
            check("lat1_ack_gap", t1 - t0, 3);
        end

        // Reset during the second ACCESS cycle of a D write.
        begin : abort
            bit seen;
            @(negedge clk);
            bus4.d_req = 1; bus4.d_we = 1; bus4.d_addr = 32'h0000_2000; bus4.d_wdata = 32'hBAD0_BAD0;
            seen = 0;
            repeat (2) begin
                @(negedge clk);
                if (bus4.mem_we || bus4.d_ack) seen = 1;
            end
            rst_n = 0;
            idle_inputs();
            @(negedge clk);
            chk_idle4("abort");
            rst_n = 1;
            repeat (8) begin
                @(negedge clk);
                if (bus4.mem_we || bus4.d_ack || bus4.i_ack) seen = 1;
            end
            check("abort_no_we_or_ack", seen, 0);
            check("abort_mem_unchanged", mem[12'h800], 32'h1234_5678);
        end

        // Random traffic against a transaction-level model: the memory is free
        // again MEM_LATENCY+2 cycles after a grant, the ack lands
        // MEM_LATENCY+1 cycles after it, conflicts alternate.
        begin : rnd
            int free_at, ack_i_at, ack_d_at;
            bit last_d, pend_i, pend_d, gi, gd, cool_i, cool_d, want_i, want_d, take_d;
            bit exp_ia, exp_da;
            logic [31:0] exp_i_data, exp_d_data;
            free_at = 0; ack_i_at = -1; ack_d_at = -1;
            last_d = 0; pend_i = 0; pend_d = 0; gi = 0; gd = 0;
            exp_i_data = 0; exp_d_data = 0;
            for (int n = 0; n < 800; n++) begin
                @(negedge clk);
                exp_ia = gi && (ack_i_at == n);
                exp_da = gd && (ack_d_at == n);
                check("rnd_i", {bus4.i_ack, bus4.i_rdata}, {exp_ia, exp_ia ? exp_i_data : 32'h0});
                check("rnd_d", {bus4.d_ack, bus4.d_rdata}, {exp_da, exp_da ? exp_d_data : 32'h0});
                cool_i = exp_ia;
                cool_d = exp_da;
                if (exp_ia) begin bus4.i_req = 0; pend_i = 0; gi = 0; end
                if (exp_da) begin bus4.d_req = 0; pend_d = 0; gd = 0; end
                if (!pend_i && !cool_i && $urandom_range(0, 2) == 0) begin
                    pend_i = 1; bus4.i_req = 1;
                    bus4.i_addr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                end
                if (!pend_d && !cool_d && $urandom_range(0, 2) == 0) begin
                    pend_d = 1; bus4.d_req = 1;
                    bus4.d_we = 1'($urandom_range(0, 1));
                    bus4.d_addr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                    bus4.d_wdata = $urandom;
                end
                want_i = pend_i && !gi;
                want_d = pend_d && !gd;
                if (n >= free_at && (want_i || want_d)) begin
                    take_d  = (want_i && want_d) ? !last_d : want_d;
                    last_d  = take_d;
                    free_at = n + 6;
                    if (take_d) begin
                        gd = 1; ack_d_at = n + 5;
                        if (bus4.d_we) begin
                            ref_mem[bus4.d_addr[13:2]] = bus4.d_wdata;
                            exp_d_data = 0;
                        end else begin
                            exp_d_data = ref_mem[bus4.d_addr[13:2]];
                        end
                    end else begin
                        gi = 1; ack_i_at = n + 5;
                        exp_i_data = ref_mem[bus4.i_addr[13:2]];
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Sequencing controller and two-requester arbiter for the single-ported main memory (`dram_main_mem`). It shares the memory between the instruction-fetch miss path (read-only) and the data-cache miss/write-through path (read or write). It serialises their accesses, models a fixed multi-cycle memory latency, and returns one-cycle acknowledges that the pipeline uses to release its stalls.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: data and address width.
- `MEM_LATENCY`, default 4: cycles an access occupies the memory, legal range 1–15.

Ports:
- `clk`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-low.
- `i_req`, in, 1: instruction-side read request, held level until `i_ack`.
- `i_addr`, in, `DATA_WIDTH`: instruction-side byte address.
- `i_ack`, out, 1: one-cycle completion pulse for the instruction side.
- `i_rdata`, out, `DATA_WIDTH`: read word, valid while `i_ack`=1.
- `d_req`, in, 1: data-side request, held level until `d_ack`.
- `d_we`, in, 1: data-side request is a write (1) or a read (0).
- `d_addr`, in, `DATA_WIDTH`: data-side byte address.
- `d_wdata`, in, `DATA_WIDTH`: data-side write word.
- `d_ack`, out, 1: one-cycle completion pulse for the data side.
- `d_rdata`, out, `DATA_WIDTH`: read word, valid while `d_ack`=1.
- `mem_re`, out, 1: read enable to main memory.
- `mem_we`, out, 1: write enable to main memory.
- `mem_addr`, out, `DATA_WIDTH`: memory address, word-aligned as `{addr[31:2],2'b00}`.
- `mem_wd`, out, `DATA_WIDTH`: memory write data.
- `mem_rd`, in, `DATA_WIDTH`: memory read data, combinational from `mem_addr`.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: samples the requests. If either is high, it grants one, latches address, write flag and write data into internal registers, loads `cnt`=`MEM_LATENCY`-1, and moves to ACCESS.
  - ACCESS: drives `mem_addr` from the latched address. A read holds `mem_re`=1 on every ACCESS cycle. A write drives `mem_wd` and asserts `mem_we` only on the cycle where `cnt`=0, giving exactly one write per transaction. Decrements `cnt`; when `cnt`=0 it captures `mem_rd` into the read register and moves to RESP.
  - RESP: asserts the granted side's ack for exactly one cycle, with its rdata equal to the captured word (0 for writes), then returns to IDLE.
- Arbitration:
  - A single request wins immediately.
  - When both requests are high in IDLE, grant goes to the side not granted last (round-robin).
  - The `last_grant` register updates only on a grant. Its reset value is I, so D wins the first conflict.
- Requester rule: `req` must be low in the cycle after its ack. Requesters clear `req` on the clock edge where ack=1, so IDLE never re-grants a completed request.
- Inputs that change during ACCESS or RESP are ignored; the latched values are used.
- An ungranted request remains pending and is served in the next IDLE.
- `i_rdata` and `d_rdata` are 0 whenever their ack is 0.

## Timing
- Request high in IDLE at cycle T leads to:
  - ACCESS on cycles T+1 to T+`MEM_LATENCY`.
  - RESP and ack on cycle T+`MEM_LATENCY`+1.
  - Earliest next grant at T+`MEM_LATENCY`+2.
- Back-to-back throughput is one transaction every `MEM_LATENCY`+2 cycles.
- With `MEM_LATENCY`=1, ACCESS lasts exactly one cycle, and the write pulse and read capture fall on that same cycle.
- Reset values, applied at the clock edge with `reset`=0:
  - State is IDLE and `cnt`=0.
  - `last_grant` is I.
  - All outputs are 0: `mem_re`, `mem_we`, `mem_addr`, `mem_wd`, both acks, both rdata outputs, and `busy`.
- Reset asserted during ACCESS or RESP aborts the transaction. No ack is issued. A write aborted before its `cnt`=0 cycle is not performed. Requesters must re-issue after reset.
- `cnt` is 4 bits wide and never wraps, because it is reloaded only in IDLE.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t`.
  - `typedef enum logic {GRANT_I, GRANT_D} grant_t`.
  - The `MEM_LATENCY` bound constant.
- Sub-module `rr_arbiter2` provides the two-input round-robin grant logic: inputs are the two requests plus a grant-taken strobe; it holds the `last_grant` register and outputs the grant.
- The top module contains the FSM, the latency counter, the latch registers and the memory-port drive.

## Test plan
- Single I read, `MEM_LATENCY`=4, `i_addr`=0x0000_1006, memory word at 0x1004 is 0xDEADBEEF:
  - `mem_addr`=0x0000_1004 and `mem_re`=1 on exactly 4 cycles.
  - `i_ack`=1 with `i_rdata`=0xDEADBEEF 5 cycles after the request; `d_ack` stays 0.
- Single D write to 0x2000 with data 0x12345678: `mem_we` pulses exactly once, then `d_ack`. A subsequent D read of 0x2000 returns 0x12345678.
- Simultaneous `i_req` and `d_req` directly after reset, both held: D is acked first, then I. Repeating the conflict alternates the grant: I, then D.
- `d_req` rises while an I transaction is in ACCESS: the D address and write data are not sampled until the next IDLE. D completes 6 cycles after the I ack.
- `reset`=0 during the second ACCESS cycle of a D write: no `mem_we`, no ack, memory is unchanged, and all outputs are 0 on the following cycle.
- `MEM_LATENCY`=1 back-to-back I reads: acks arrive 3 cycles apart, and each rdata matches its own address.
